// File: rtl/rx_frame_controller.sv
// rtl/rx_frame_controller.sv - framed packet assembler and streamer for the serial RX byte receiver
module rx_frame_controller #(
    parameter logic [7:0] HEADER         = 8'hAA,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 1000
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       RX_Done_Sig,
    input  logic [7:0] RX_Data,
    output logic       RX_En_Sig,
    output logic [7:0] Out_Data,
    output logic       Out_Valid,
    output logic       Out_Last,
    input  logic       Out_Ready,
    output logic       Err_Sig,
    output logic [1:0] Err_Code,
    output logic [7:0] Frame_Count
);

    localparam int          IDX_W      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int          BUF_DEPTH  = 1 << IDX_W;
    localparam logic [7:0]  MAX_LEN_B  = 8'(MAX_LEN);
    // The error fires on the idle cycle that brings the count up to TIMEOUT_CYCLES.
    localparam logic [15:0] IDLE_LIMIT = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CSUM    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [2:0] {
        S_HUNT,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_OUTPUT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [7:0]  len;
    logic [7:0]  csum;
    logic [7:0]  idx;
    logic [15:0] idle_cnt;
    logic [7:0]  pbuf [BUF_DEPTH];

    logic        err_evt;
    logic [1:0]  err_code_nxt;
    logic        byte_acc;
    logic        in_frame;
    logic        timeout_hit;
    logic        at_last;
    logic        handshake;

    assign byte_acc    = RX_Done_Sig && RX_En_Sig;
    assign in_frame    = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
    assign timeout_hit = in_frame && !byte_acc && (idle_cnt == IDLE_LIMIT);
    assign at_last     = (idx == len - 8'd1);

    // idx doubles as the payload write pointer and the output read pointer.
    assign Out_Valid = (state == S_OUTPUT);
    assign handshake = Out_Valid && Out_Ready;
    assign Out_Last  = Out_Valid && at_last;
    assign Out_Data  = Out_Valid ? pbuf[idx[IDX_W-1:0]] : 8'd0;

    // State register.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= S_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and error detection; a byte arriving on the limit cycle suppresses the timeout.
    always_comb begin
        state_nxt    = state;
        err_evt      = 1'b0;
        err_code_nxt = 2'd0;
        case (state)
            S_HUNT: begin
                if (byte_acc && (RX_Data == HEADER)) begin
                    state_nxt = S_LEN;
                end
            end
            S_LEN: begin
                if (byte_acc) begin
                    if ((RX_Data == 8'd0) || (RX_Data > MAX_LEN_B)) begin
                        err_evt      = 1'b1;
                        err_code_nxt = ERR_LEN;
                        state_nxt    = S_HUNT;
                    end else begin
                        state_nxt = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (byte_acc && at_last) begin
                    state_nxt = S_CSUM;
                end
            end
            S_CSUM: begin
                if (byte_acc) begin
                    if (RX_Data == csum) begin
                        state_nxt = S_OUTPUT;
                    end else begin
                        err_evt      = 1'b1;
                        err_code_nxt = ERR_CSUM;
                        state_nxt    = S_HUNT;
                    end
                end
            end
            S_OUTPUT: begin
                if (handshake && at_last) begin
                    state_nxt = S_HUNT;
                end
            end
            default: state_nxt = S_HUNT;
        endcase
        if (timeout_hit) begin
            err_evt      = 1'b1;
            err_code_nxt = ERR_TIMEOUT;
            state_nxt    = S_HUNT;
        end
    end

    // Frame bookkeeping, receiver enable, idle timer and registered error reporting.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            RX_En_Sig   <= 1'b0;
            Err_Sig     <= 1'b0;
            Err_Code    <= 2'd0;
            Frame_Count <= 8'd0;
            len         <= 8'd0;
            csum        <= 8'd0;
            idx         <= 8'd0;
            idle_cnt    <= 16'd0;
        end else begin
            RX_En_Sig <= (state_nxt != S_OUTPUT);
            Err_Sig   <= err_evt;
            if (err_evt) begin
                Err_Code <= err_code_nxt;
            end
            if (in_frame && !byte_acc) begin
                idle_cnt <= idle_cnt + 16'd1;
            end else begin
                idle_cnt <= 16'd0;
            end
            case (state)
                S_LEN: begin
                    if (byte_acc) begin
                        len  <= RX_Data;
                        csum <= RX_Data;
                        idx  <= 8'd0;
                    end
                end
                S_PAYLOAD: begin
                    if (byte_acc) begin
                        csum <= csum + RX_Data;
                        idx  <= idx + 8'd1;
                    end
                end
                S_CSUM: begin
                    if (byte_acc) begin
                        idx <= 8'd0;
                    end
                end
                S_OUTPUT: begin
                    if (handshake) begin
                        if (at_last) begin
                            Frame_Count <= Frame_Count + 8'd1;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Payload buffer; contents survive errors and resets, only the pointers are reset.
    always_ff @(posedge CLK) begin
        if ((state == S_PAYLOAD) && byte_acc) begin
            pbuf[idx[IDX_W-1:0]] <= RX_Data;
        end
    end

endmodule

// File: tb/tb_rx_frame_controller.sv
// tb/tb_rx_frame_controller.sv - randomized self-checking bench for rx_frame_controller
module tb_rx_frame_controller;

    localparam logic [7:0] HDR  = 8'hAA;
    localparam int         MAXL = 16;
    localparam int         TO   = 50;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       RX_Done_Sig = 1'b0;
    logic [7:0] RX_Data = 8'd0;
    logic       Out_Ready = 1'b0;
    logic       RX_En_Sig;
    logic [7:0] Out_Data;
    logic       Out_Valid;
    logic       Out_Last;
    logic       Err_Sig;
    logic [1:0] Err_Code;
    logic [7:0] Frame_Count;

    rx_frame_controller #(
        .HEADER        (HDR),
        .MAX_LEN       (MAXL),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK        (CLK),
        .RSTn       (RSTn),
        .RX_Done_Sig(RX_Done_Sig),
        .RX_Data    (RX_Data),
        .RX_En_Sig  (RX_En_Sig),
        .Out_Data   (Out_Data),
        .Out_Valid  (Out_Valid),
        .Out_Last   (Out_Last),
        .Out_Ready  (Out_Ready),
        .Err_Sig    (Err_Sig),
        .Err_Code   (Err_Code),
        .Frame_Count(Frame_Count)
    );

    always #5 CLK = ~CLK;

    typedef logic [7:0] bq_t[$];

    int         n_checks = 0;
    int         n_pass = 0;
    int         model_frames = 0;
    logic [8:0] obs_out[$];
    logic [8:0] exp_out[$];
    logic [1:0] obs_err[$];
    logic [1:0] exp_err[$];
    bit         ready_mode = 1'b0;
    bit         ready_val = 1'b1;
    bq_t        cur;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Consumer: random or forced ready, changed shortly after each rising edge.
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            Out_Ready = ready_mode ? ($urandom_range(0, 3) != 0) : ready_val;
        end
    end

    // Output monitor sampled on the falling edge.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'd0;
    logic       prev_last = 1'b0;
    always @(negedge CLK) begin
        if (!RSTn) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", 32'(Out_Valid), 32'd1);
                chk("hold_data", 32'(Out_Data), 32'(prev_data));
                chk("hold_last", 32'(Out_Last), 32'(prev_last));
            end
            if (Out_Valid) chk("rx_en_in_output", 32'(RX_En_Sig), 32'd0);
            if (Out_Valid && Out_Ready) obs_out.push_back({Out_Last, Out_Data});
            if (Err_Sig) obs_err.push_back(Err_Code);
            prev_stall <= Out_Valid && !Out_Ready;
            prev_data  <= Out_Data;
            prev_last  <= Out_Last;
        end
    end

    // Frame-level reference: parse the whole accepted byte stream; a stream ending inside a frame times out.
    task automatic model_stream(input bq_t s);
        int         i = 0;
        int         n;
        logic [7:0] sum;
        while (i < s.size()) begin
            if (s[i] != HDR) begin
                i++;
                continue;
            end
            i++;
            if (i >= s.size()) begin
                exp_err.push_back(2'd3);
                break;
            end
            n = int'(s[i]);
            i++;
            if (n == 0 || n > MAXL) begin
                exp_err.push_back(2'd1);
                continue;
            end
            if (i + n + 1 > s.size()) begin
                exp_err.push_back(2'd3);
                break;
            end
            sum = n[7:0];
            for (int j = 0; j < n; j++) sum = sum + s[i+j];
            if (s[i+n] != sum) begin
                exp_err.push_back(2'd2);
            end else begin
                for (int j = 0; j < n; j++) exp_out.push_back({(j == n - 1), s[i+j]});
                model_frames++;
            end
            i += n + 1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int w = 0;
        repeat (gap) begin
            @(posedge CLK);
            #1;
        end
        while (!RX_En_Sig && w < 500) begin
            @(posedge CLK);
            #1;
            w++;
        end
        chk("rx_en_wait", 32'(RX_En_Sig), 32'd1);
        RX_Done_Sig = 1'b1;
        RX_Data     = b;
        @(posedge CLK);
        #1;
        RX_Done_Sig = 1'b0;
    endtask

    task automatic feed(input bit rand_gap);
        foreach (cur[i]) send_byte(cur[i], rand_gap ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic finish_seq();
        int quiet = 0;
        int t = 0;
        int m;
        while (quiet < TO + 5 && t < 20000) begin
            @(posedge CLK);
            #1;
            t++;
            if (!Out_Valid && RX_En_Sig) quiet++;
            else quiet = 0;
        end
        chk("quiesce", 32'(quiet >= TO + 5), 32'd1);
        exp_out.delete();
        exp_err.delete();
        model_stream(cur);
        chk("out_count", 32'(obs_out.size()), 32'(exp_out.size()));
        m = (obs_out.size() < exp_out.size()) ? obs_out.size() : exp_out.size();
        for (int i = 0; i < m; i++) chk("out_byte", 32'(obs_out[i]), 32'(exp_out[i]));
        chk("err_count", 32'(obs_err.size()), 32'(exp_err.size()));
        m = (obs_err.size() < exp_err.size()) ? obs_err.size() : exp_err.size();
        for (int i = 0; i < m; i++) chk("err_code", 32'(obs_err[i]), 32'(exp_err[i]));
        if (exp_err.size() > 0) chk("err_code_hold", 32'(Err_Code), 32'(exp_err[exp_err.size()-1]));
        chk("frame_count", 32'(Frame_Count), 32'(model_frames % 256));
        obs_out.delete();
        obs_err.delete();
    endtask

    // kind: 0 good, 1 bad checksum, 2 bad length, 3 garbage, 4 good with header-valued payload byte
    task automatic add_frame(input int kind);
        int         n;
        logic [7:0] sum;
        logic [7:0] b;
        case (kind)
            2: begin
                cur.push_back(HDR);
                if ($urandom_range(0, 1) == 0) cur.push_back(8'd0);
                else cur.push_back(8'($urandom_range(MAXL + 1, 255)));
            end
            3: begin
                repeat ($urandom_range(1, 3)) begin
                    b = 8'($urandom);
                    if (b == HDR) b = 8'h55;
                    cur.push_back(b);
                end
            end
            default: begin
                n = $urandom_range(1, MAXL);
                cur.push_back(HDR);
                cur.push_back(n[7:0]);
                sum = n[7:0];
                for (int j = 0; j < n; j++) begin
                    b = 8'($urandom);
                    if (kind == 4 && j == 0) b = HDR;
                    cur.push_back(b);
                    sum = sum + b;
                end
                cur.push_back((kind == 1) ? sum + 8'd1 : sum);
            end
        endcase
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int k;
        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_rx_en", 32'(RX_En_Sig), 32'd0);
        chk("rst_out_valid", 32'(Out_Valid), 32'd0);
        chk("rst_out_data", 32'(Out_Data), 32'd0);
        chk("rst_out_last", 32'(Out_Last), 32'd0);
        chk("rst_err_sig", 32'(Err_Sig), 32'd0);
        chk("rst_err_code", 32'(Err_Code), 32'd0);
        chk("rst_frame_count", 32'(Frame_Count), 32'd0);
        RSTn = 1'b1;
        chk("rx_en_before_first_edge", 32'(RX_En_Sig), 32'd0);
        @(posedge CLK);
        #1;
        chk("rx_en_first_cycle", 32'(RX_En_Sig), 32'd1);

        // Good frame with exact output timing
        ready_mode = 1'b0;
        ready_val  = 1'b1;
        @(posedge CLK);
        #1;
        cur = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
        feed(1'b0);
        chk("t1_valid0", 32'(Out_Valid), 32'd1);
        chk("t1_data0", 32'(Out_Data), 32'h11);
        chk("t1_last0", 32'(Out_Last), 32'd0);
        chk("t1_rxen0", 32'(RX_En_Sig), 32'd0);
        @(posedge CLK);
        #1;
        chk("t1_data1", 32'(Out_Data), 32'h22);
        chk("t1_rxen1", 32'(RX_En_Sig), 32'd0);
        @(posedge CLK);
        #1;
        chk("t1_data2", 32'(Out_Data), 32'h33);
        chk("t1_last2", 32'(Out_Last), 32'd1);
        chk("t1_rxen2", 32'(RX_En_Sig), 32'd0);
        @(posedge CLK);
        #1;
        chk("t1_valid_done", 32'(Out_Valid), 32'd0);
        chk("t1_rxen_back", 32'(RX_En_Sig), 32'd1);
        finish_seq();

        // Bad checksum, then recovery
        cur = '{8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68, 8'hAA, 8'h01, 8'h7F, 8'h80};
        feed(1'b1);
        finish_seq();

        // Bad lengths (zero and MAX_LEN+1), then recovery
        cur = '{8'hAA, 8'h00, 8'hAA, 8'h11, 8'hAA, 8'h01, 8'h7F, 8'h80};
        feed(1'b1);
        finish_seq();

        // Timeout latency
        cur = '{8'hAA, 8'h02, 8'h11};
        feed(1'b0);
        k = 0;
        for (int c = 1; c <= TO + 10; c++) begin
            @(posedge CLK);
            #1;
            if (Err_Sig) begin
                k = c;
                break;
            end
        end
        chk("timeout_latency", 32'(k), 32'(TO));
        chk("timeout_code", 32'(Err_Code), 32'd3);
        finish_seq();
        cur = '{8'h55, 8'hAA, 8'h01, 8'h7F, 8'h80};
        feed(1'b1);
        finish_seq();

        // Back-pressure with ignored receiver pulses during output
        ready_val = 1'b0;
        cur = '{8'hAA, 8'h02, 8'h5A, 8'h3C, 8'h98};
        feed(1'b0);
        for (int c = 0; c < 5; c++) begin
            chk("bp_valid", 32'(Out_Valid), 32'd1);
            chk("bp_data", 32'(Out_Data), 32'h5A);
            chk("bp_last", 32'(Out_Last), 32'd0);
            RX_Done_Sig = (c % 2 == 0);
            RX_Data     = (c == 2) ? 8'h01 : HDR;
            @(posedge CLK);
            #1;
        end
        RX_Done_Sig = 1'b0;
        ready_val   = 1'b1;
        finish_seq();

        // Reset in the middle of a payload
        cur = '{8'hAA, 8'h04, 8'h01, 8'h02};
        feed(1'b0);
        RSTn = 1'b0;
        #1;
        chk("mid_rst_rx_en", 32'(RX_En_Sig), 32'd0);
        chk("mid_rst_valid", 32'(Out_Valid), 32'd0);
        chk("mid_rst_data", 32'(Out_Data), 32'd0);
        chk("mid_rst_err_sig", 32'(Err_Sig), 32'd0);
        chk("mid_rst_err_code", 32'(Err_Code), 32'd0);
        chk("mid_rst_frame_count", 32'(Frame_Count), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RSTn = 1'b1;
        model_frames = 0;
        @(posedge CLK);
        #1;
        chk("post_rst_rx_en", 32'(RX_En_Sig), 32'd1);
        cur = '{8'hAA, 8'h02, 8'hAA, 8'h10, 8'hBC};
        feed(1'b1);
        finish_seq();

        // 256 more good frames: Frame_Count wraps
        model_frames = 0;
        RSTn = 1'b0;
        @(posedge CLK);
        #1;
        RSTn = 1'b1;
        @(posedge CLK);
        #1;
        for (int bt = 0; bt < 8; bt++) begin
            cur.delete();
            repeat (32) add_frame(0);
            feed(1'b0);
            finish_seq();
        end
        chk("wrap_to_zero", 32'(Frame_Count), 32'd0);

        // Random mixed streams under random back-pressure
        ready_mode = 1'b1;
        for (int r = 0; r < 30; r++) begin
            cur.delete();
            repeat ($urandom_range(1, 6)) add_frame($urandom_range(0, 4));
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 2)) if (cur.size() > 0) void'(cur.pop_back());
            end
            feed(1'b1);
            finish_seq();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rx_frame_controller.md
Name: rx_frame_controller

Overview:
Sequences the serial RX byte receiver and assembles framed packets from its byte stream. Frame format: header byte, length byte, payload bytes, checksum byte. It hunts for the header, validates length and checksum, and buffers the payload. It streams good frames to a downstream consumer over a valid/ready handshake. RX_En_Sig throttles the receiver while a frame is draining.

Parameters:
HEADER, 8'hAA, frame start byte
MAX_LEN, 16, maximum payload length in bytes (1..255); sets payload buffer depth
TIMEOUT_CYCLES, 1000, idle CLK cycles allowed between bytes inside a frame (1..65535)

Ports:
CLK  input  1  system clock
RSTn  input  1  reset, asynchronous, active-low
RX_Done_Sig  input  1  one-cycle pulse, receiver has a byte
RX_Data  input  8  received byte, valid while RX_Done_Sig=1
RX_En_Sig  output  1  enable to the receiver; 1 = bytes accepted
Out_Data  output  8  payload byte to consumer
Out_Valid  output  1  Out_Data valid
Out_Last  output  1  final payload byte of the frame, qualified by Out_Valid
Out_Ready  input  1  consumer accepts byte
Err_Sig  output  1  one-cycle pulse on frame error
Err_Code  output  2  last error: 0 none, 1 bad length, 2 bad checksum, 3 timeout
Frame_Count  output  8  good frames delivered, wraps 255->0

Behaviour:
- Reset values: all outputs 0, state HUNT, counters 0. RX_En_Sig goes to 1 in the first cycle after RSTn deasserts.
- Reset mid-operation: immediate return to reset values; partial frame discarded; no Err_Sig pulse.
- A byte is accepted only when RX_Done_Sig=1 and RX_En_Sig=1. RX_Done_Sig while RX_En_Sig=0 is ignored.
- States:
  - HUNT: accepted byte equal to HEADER goes to LEN; any other byte is discarded silently with no error.
  - LEN: byte N. If N=0 or N>MAX_LEN: Err_Code=1, go to HUNT. Otherwise store N, checksum accumulator = N, index = 0, go to PAYLOAD.
  - PAYLOAD: write byte to buffer[index], accumulator += byte (mod 256), index++. After the Nth byte, go to CSUM.
  - CSUM: byte == accumulator goes to OUTPUT. Otherwise Err_Code=2, go to HUNT. Header is excluded from the checksum.
  - OUTPUT: RX_En_Sig=0.
    - Out_Valid=1 with Out_Data=buffer[0] starting the cycle after the checksum byte is accepted (latency 1).
    - On each Valid&Ready cycle, advance to the next byte.
    - Out_Last=1 exactly with byte N-1.
    - Out_Data and Out_Last are held stable while Out_Ready=0.
    - On handshake of the last byte: Frame_Count++, go to HUNT. Next cycle: Out_Valid=0, RX_En_Sig=1.
- RX_En_Sig=1 in HUNT, LEN, PAYLOAD and CSUM.
- Timeout:
  - 16-bit idle counter clears on every accepted byte and counts only in LEN, PAYLOAD and CSUM.
  - When it reaches TIMEOUT_CYCLES with no byte: Err_Code=3, go to HUNT.
  - If a byte arrives in the same cycle the limit is reached, the byte wins and there is no timeout.
  - No timeout in HUNT or OUTPUT.
- Errors: Err_Sig pulses 1 cycle, asserted the cycle after the detecting event. Err_Code updates in that same cycle and holds until the next error. On error the partial frame is dropped; the buffer is not cleared.
- A header-valued byte inside LEN, PAYLOAD or CSUM is treated as data, with no resync.
- Frame_Count wraps 255->0 with no flag.

Test Plan:
1. Good frame: bytes AA 03 11 22 33 69, Out_Ready=1 → Out_Data 11,22,33 on consecutive cycles; Out_Last on 33; Frame_Count=1; Err_Sig never pulses; RX_En_Sig=0 for 3 cycles, then 1.
2. Bad checksum: AA 03 11 22 33 68 → Err_Sig one pulse, Err_Code=2, no Out_Valid, next frame AA 01 7F 80 delivers 7F.
3. Bad length: AA 00, then AA 11 (MAX_LEN=16) → two Err_Sig pulses, Err_Code=1 each, controller in HUNT after each.
4. Timeout: AA 02 11, then silence → Err_Sig exactly TIMEOUT_CYCLES cycles after the 11 byte, Err_Code=3. Garbage before the header (55 AA 01 7F 80) → 7F delivered, no error.
5. Back-pressure: good 2-byte frame with Out_Ready=0 for 5 cycles → Out_Data/Out_Last held; RX_Done_Sig pulses injected during OUTPUT are ignored (Frame_Count +1 only, buffer unchanged).
6. Reset mid-PAYLOAD after AA 04 01 02 → all outputs 0, no Err_Sig. A subsequent good frame delivers correctly. Also: 256 good frames → Frame_Count wraps to 0.
